alu_req_scheduler: RTL and testbench
====================================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one 4-bit ALU (add/mul/and/or/nor/xor, ok/ack handshake) between two requesters.
//  Arbitrates, registers the winning op and operands, and sequences the ALU's load/ok/ack protocol.
//  Captures the 9-bit result and returns it on the winner's response channel.
//  Sits between the requester logic and the ALU instance. Only one ALU operation is in flight at a time.
// PARAMETERS
//  OP_W    3  ALU opcode width (control_signal)
//  DATA_W  4  operand width (A_in/B_in)
//  RES_W   9  ALU result width (out)
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  req0_valid   in   1       requester 0 has an op
//  req0_ready   out  1       requester 0 op accepted this cycle (valid&ready)
//  req0_op      in   OP_W    opcode
//  req0_a/b     in   DATA_W  operands
//  resp0_valid  out  1       result for requester 0 pending
//  resp0_ready  in   1       requester 0 consumes result
//  resp0_data   out  RES_W   result
//  resp0_err    out  1       op was illegal, data=0
//  req1_* / resp1_*  same as requester 0
//  alu_ctrl     out  OP_W    to ALU control_signal
//  alu_a/b      out  DATA_W  to ALU A_in/B_in
//  alu_ok       out  1       to ALU ok
//  alu_ack      out  1       to ALU ack
//  alu_out      in   RES_W   from ALU out
// BEHAVIOUR
//  Reset: all outputs are 0; state=INIT; rr pointer favours requester 0.
//  alu_ctrl=000 in every state except ISSUE, so the ALU idles in its load state.
//  INIT (1 cyc): alu_ack=1 to flush an ALU left in its wait-ack state -> IDLE.
//  IDLE: arbitrate among valid requesters and pulse the winner's reqN_ready (1 cyc).
//   Register op/a/b and the grant id. Requesters with resp pending are masked.
//  Legal ops: 001 add, 010 mul, 011 and, 100 or, 110 xor.
//   These go IDLE -> ISSUE -> GO -> CAPT -> RESP.
//  Illegal ops: 000, 101 (the ALU never exits nor), 111.
//   These go IDLE -> RESP with err=1, data=0. The ALU is never touched.
//  ISSUE: alu_ctrl=op, alu_a/b=operands. The ALU loads op at the cycle end.
//  GO: alu_ok=1 with operands held. The ALU writes out at the cycle end.
//  CAPT: alu_ack=1. Register alu_out into the response data.
//   For add, bit8 is carry and bits7:4 are 0. The ALU returns to its load state.
//  RESP: respN_valid=1 and data/err stable until respN_ready. Then -> IDLE, same cycle as ready.
//  Latency: accept at cycle T -> respN_valid high at T+4 (legal) or T+1 (illegal).
//  Round-robin: after a grant, the pointer favours the other requester. A lone requester always wins.
//  Both requesters valid in IDLE: the rr pointer picks the winner; the loser's ready stays 0 and it keeps valid.
//  req inputs are ignored outside IDLE. reqN_ready is never asserted twice for one op.
//  rst in any state (mid-op included): the next cycle is INIT. Pending responses are dropped.
//   INIT's ack recovers the ALU from its wait-ack state.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie; the rr pointer is removed.
//  ARB_FIXED_PRIO_EN undefined: round-robin as above (default).
// STRUCTURE
//  alu_sched_defs.vh holds:
//   - state encodings: INIT, IDLE, ISSUE, GO, CAPT, RESP
//   - opcode constants: OP_NOP, OP_ADD, OP_MUL, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_WAIT
//   - an is_legal_op function
//  Sub-module arb2_rr: 2-way arbiter.
//   Inputs: clk, rst, req[1:0], mask[1:0], adv. Output: one-hot gnt[1:0].
//   Holds the rr pointer and the macro-dependent fixed-priority logic.
//  The top holds the FSM, op/operand/result registers and the response channels.
// TESTING
//  1. After rst, req0 add a=4'hF,b=4'h1 -> ready at T, resp0_valid at T+4, data=9'h100, err=0.
//  2. req1 mul a=4'hF,b=4'hF -> resp1_data=9'h0E1. alu_ok and alu_ack are single 1-cycle pulses.
//  3. Both valid, xor 4'hA^4'h5 and and 4'hC&4'hA, resp always ready.
//     -> req0 first, data=9'h00F, then req1, data=9'h008. With ARB_FIXED_PRIO_EN, repeated req0 wins every tie.
//  4. req0 op=101 -> resp0_err=1, data=0 at T+1. alu_ctrl stays 000 and alu_ok never rises.
//  5. resp0_ready held low 10 cycles -> data stable. req0 is masked and req1 is still served afterwards.
//  6. rst asserted during GO -> outputs 0 next cycle, INIT pulses alu_ack.
//     A following add 3+4 returns 9'h007.

Source files
------------

// File: rtl/alu_req_scheduler_pkg.sv
// Shared widths, FSM state codes, ALU opcodes and the legal-op check for alu_req_scheduler.
package alu_req_scheduler_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 4;
    localparam int RES_W  = 9;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_GO    = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_WAIT = 3'b111;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

    // NOR is excluded: the ALU never leaves its NOR state.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_MUL, OP_AND, OP_OR, OP_XOR: is_legal_op = 1'b1;
            default:                               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// One requester channel: op request handshake plus the matching result response.
interface alu_req_scheduler_if;
    import alu_req_scheduler_pkg::*;

    logic              valid;
    logic              ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              resp_valid;
    logic              resp_ready;
    logic [RES_W-1:0]  resp_data;
    logic              resp_err;

    modport master (
        output valid, op, a, b, resp_ready,
        input  ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  valid, op, a, b, resp_ready,
        output ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/alu_req_scheduler_arb2_rr.sv
// Two-way arbiter with one-hot grant; round-robin by default, fixed priority to
// requester 0 when ARB_FIXED_PRIO_EN is defined.
module arb2_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic [1:0] w_req;

    assign w_req = req & ~mask;

`ifdef ARB_FIXED_PRIO_EN
    // Ports kept identical to the round-robin build so the top is unchanged.
    logic w_unused;
    assign w_unused = ^{clk, rst, adv};

    always_comb begin
        gnt = 2'b00;
        if (w_req[0])
            gnt = 2'b01;
        else if (w_req[1])
            gnt = 2'b10;
    end
`else
    logic r_ptr;  // 1 = requester 1 preferred on a tie

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (adv)
            r_ptr <= gnt[0];
    end

    always_comb begin
        gnt = 2'b00;
        case (w_req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ok/ack-handshake ALU between two requesters, one op in flight at a time.
// Arbitration policy is selected by ARB_FIXED_PRIO_EN inside arb2_rr.
//
// state | meaning
// INIT  | flush ALU out of wait-ack with one ack pulse
// IDLE  | arbitrate, accept one op
// ISSUE | drive opcode/operands, ALU loads op
// GO    | ok pulse, ALU computes
// CAPT  | ack pulse, register ALU result
// RESP  | hold result on the winner's response channel
module alu_req_scheduler
    import alu_req_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    alu_req_scheduler_if.slave   req0,
    alu_req_scheduler_if.slave   req1,
    output logic [OP_W-1:0]      alu_ctrl,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic                 alu_ok,
    output logic                 alu_ack,
    input  logic [RES_W-1:0]     alu_out
);

    logic [2:0]       r_state;
    logic             r_live;
    alu_req_t         r_req;
    logic             r_gnt_id;
    logic [RES_W-1:0] r_data;
    logic             r_err;

    logic [1:0]       w_gnt;
    logic [1:0]       w_mask;
    logic             w_idle;
    logic             w_fire;
    logic             w_resp;
    logic             w_drive;
    logic             w_resp_ready;
    alu_req_t         w_win;

    assign w_idle       = r_live & ~rst & (r_state == ST_IDLE);
    assign w_fire       = w_idle & (|w_gnt);
    assign w_resp       = r_live & (r_state == ST_RESP);
    assign w_mask       = {w_resp & r_gnt_id, w_resp & ~r_gnt_id};
    assign w_resp_ready = r_gnt_id ? req1.resp_ready : req0.resp_ready;
    assign w_win        = w_gnt[1] ? {req1.op, req1.a, req1.b} : {req0.op, req0.a, req0.b};

    arb2_rr u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({req1.valid, req0.valid}),
        .mask (w_mask),
        .adv  (w_fire),
        .gnt  (w_gnt)
    );

    // r_live holds every output low for the first cycle after reset, so INIT
    // lasts one extra cycle and its ack pulse follows the all-zero cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_live   <= 1'b0;
            r_req    <= '0;
            r_gnt_id <= 1'b0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_INIT: if (r_live) r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (w_fire) begin
                        r_req    <= w_win;
                        r_gnt_id <= w_gnt[1];
                        r_data   <= '0;
                        r_err    <= ~is_legal_op(w_win.op);
                        r_state  <= is_legal_op(w_win.op) ? ST_ISSUE : ST_RESP;
                    end
                end
                ST_ISSUE: r_state <= ST_GO;
                ST_GO:    r_state <= ST_CAPT;
                ST_CAPT: begin
                    r_data  <= alu_out;
                    r_state <= ST_RESP;
                end
                ST_RESP: if (w_resp_ready) r_state <= ST_IDLE;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign req0.ready      = w_fire & w_gnt[0];
    assign req1.ready      = w_fire & w_gnt[1];

    assign req0.resp_valid = w_resp & ~r_gnt_id;
    assign req0.resp_data  = req0.resp_valid ? r_data : '0;
    assign req0.resp_err   = req0.resp_valid & r_err;
    assign req1.resp_valid = w_resp & r_gnt_id;
    assign req1.resp_data  = req1.resp_valid ? r_data : '0;
    assign req1.resp_err   = req1.resp_valid & r_err;

    assign w_drive  = r_live & ((r_state == ST_ISSUE) | (r_state == ST_GO));
    assign alu_ctrl = (r_live && r_state == ST_ISSUE) ? r_req.op : OP_NOP;
    assign alu_a    = w_drive ? r_req.a : '0;
    assign alu_b    = w_drive ? r_req.b : '0;
    assign alu_ok   = r_live & (r_state == ST_GO);
    assign alu_ack  = r_live & ((r_state == ST_INIT) | (r_state == ST_CAPT));

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a behavioural load/ok/ack ALU model.
module tb_alu_req_scheduler;
    import alu_req_scheduler_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       alu_ctrl;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic             alu_ok;
    logic             alu_ack;
    logic [8:0]       alu_out;

    int total = 0;
    int bad   = 0;
    int okc;
    int ackc;

    always #5 clk = ~clk;

    alu_req_scheduler_if u_req0();
    alu_req_scheduler_if u_req1();

    alu_req_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (u_req0.slave),
        .req1     (u_req1.slave),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ok   (alu_ok),
        .alu_ack  (alu_ack),
        .alu_out  (alu_out)
    );

    // ALU model: 0 = load, 1 = wait ok, 2 = wait ack; powers up stuck in wait-ack.
    logic [1:0] m_st  = 2'd2;
    logic [2:0] m_op  = 3'd0;
    logic [3:0] m_a   = 4'd0;
    logic [3:0] m_b   = 4'd0;
    logic [8:0] m_out = 9'h1AA;

    assign alu_out = m_out;

    function automatic logic [8:0] alu_calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [7:0] p;
        s = a + b;
        p = a * b;
        case (op)
            OP_ADD:  return {s[4], 4'b0000, s[3:0]};
            OP_MUL:  return {1'b0, p};
            OP_AND:  return {5'b00000, a & b};
            OP_OR:   return {5'b00000, a | b};
            OP_XOR:  return {5'b00000, a ^ b};
            default: return 9'h000;
        endcase
    endfunction

    always @(posedge clk) begin
        case (m_st)
            2'd0: if (alu_ctrl != 3'b000) begin
                m_op <= alu_ctrl;
                m_a  <= alu_a;
                m_b  <= alu_b;
                m_st <= 2'd1;
            end
            2'd1: if (alu_ok) begin
                m_out <= alu_calc(m_op, m_a, m_b);
                m_st  <= 2'd2;
            end
            default: if (alu_ack) m_st <= 2'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id == 0) begin
            u_req0.valid = v; u_req0.op = op; u_req0.a = a; u_req0.b = b;
        end else begin
            u_req1.valid = v; u_req1.op = op; u_req1.a = a; u_req1.b = b;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? u_req0.ready : u_req1.ready;
    endfunction

    function automatic logic rvalid(input int id);
        return (id == 0) ? u_req0.resp_valid : u_req1.resp_valid;
    endfunction

    function automatic logic [8:0] rdata(input int id);
        return (id == 0) ? u_req0.resp_data : u_req1.resp_data;
    endfunction

    function automatic logic rerr(input int id);
        return (id == 0) ? u_req0.resp_err : u_req1.resp_err;
    endfunction

    // Entered in IDLE with requests driven; returns in the first RESP cycle.
    task automatic serve(input int id, input logic [8:0] exp_d, input logic exp_e, input logic drop, input string tag);
        #1;
        chk({tag, "_ready"}, rdy(id), 1'b1);
        chk({tag, "_other_ready"}, rdy(1 - id), 1'b0);
        tick();
        if (drop) begin
            if (id == 0) u_req0.valid = 1'b0;
            else         u_req1.valid = 1'b0;
        end
        chk({tag, "_ready_once"}, rdy(id), 1'b0);
        if (!exp_e) repeat (3) tick();
        chk({tag, "_resp_valid"}, rvalid(id), 1'b1);
        chk({tag, "_other_resp"}, rvalid(1 - id), 1'b0);
        chk({tag, "_data"}, rdata(id), exp_d);
        chk({tag, "_err"}, rerr(id), exp_e);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 3'b000, 4'h0, 4'h0);
        drive(1, 1'b0, 3'b000, 4'h0, 4'h0);
        u_req0.resp_ready = 1'b0;
        u_req1.resp_ready = 1'b0;

        repeat (2) tick();
        chk("rst_ack", alu_ack, 1'b0);
        chk("rst_ok", alu_ok, 1'b0);
        chk("rst_ctrl", alu_ctrl, 3'b000);
        chk("rst_resp0", u_req0.resp_valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("init_ack", alu_ack, 1'b1);
        chk("init_ok", alu_ok, 1'b0);
        tick();
        chk("idle_ack", alu_ack, 1'b0);

        // 1: add with carry, cycle-by-cycle ALU protocol
        drive(0, 1'b1, OP_ADD, 4'hF, 4'h1);
        #1;
        chk("t1_ready", u_req0.ready, 1'b1);
        tick();
        drive(0, 1'b0, OP_ADD, 4'hF, 4'h1);
        chk("t1_issue_ctrl", alu_ctrl, OP_ADD);
        chk("t1_issue_a", alu_a, 4'hF);
        chk("t1_issue_b", alu_b, 4'h1);
        chk("t1_ready_once", u_req0.ready, 1'b0);
        tick();
        chk("t1_go_ok", alu_ok, 1'b1);
        chk("t1_go_ctrl", alu_ctrl, 3'b000);
        chk("t1_go_a", alu_a, 4'hF);
        tick();
        chk("t1_capt_ack", alu_ack, 1'b1);
        chk("t1_capt_ok", alu_ok, 1'b0);
        chk("t1_capt_no_resp", u_req0.resp_valid, 1'b0);
        tick();
        chk("t1_resp_valid", u_req0.resp_valid, 1'b1);
        chk("t1_resp_data", u_req0.resp_data, 9'h100);
        chk("t1_resp_err", u_req0.resp_err, 1'b0);
        chk("t1_resp1_idle", u_req1.resp_valid, 1'b0);
        tick();
        chk("t1_hold_valid", u_req0.resp_valid, 1'b1);
        u_req0.resp_ready = 1'b1;
        tick();
        chk("t1_consumed", u_req0.resp_valid, 1'b0);
        u_req0.resp_ready = 1'b0;

        // 2: mul on requester 1, ok/ack are single pulses
        drive(1, 1'b1, OP_MUL, 4'hF, 4'hF);
        #1;
        chk("t2_ready", u_req1.ready, 1'b1);
        okc = 0;
        ackc = 0;
        tick();
        drive(1, 1'b0, OP_MUL, 4'hF, 4'hF);
        okc += int'(alu_ok);
        ackc += int'(alu_ack);
        repeat (3) begin
            tick();
            okc += int'(alu_ok);
            ackc += int'(alu_ack);
        end
        chk("t2_ok_pulses", okc[15:0], 16'd1);
        chk("t2_ack_pulses", ackc[15:0], 16'd1);
        chk("t2_resp_valid", u_req1.resp_valid, 1'b1);
        chk("t2_resp_data", u_req1.resp_data, 9'h0E1);
        u_req1.resp_ready = 1'b1;
        tick();

        // 3: simultaneous requests, responses always consumed
        u_req0.resp_ready = 1'b1;
        drive(0, 1'b1, OP_XOR, 4'hA, 4'h5);
        drive(1, 1'b1, OP_AND, 4'hC, 4'hA);
        serve(0, 9'h00F, 1'b0, 1'b1, "t3_first");
        tick();
        serve(1, 9'h008, 1'b0, 1'b1, "t3_second");
        tick();

        // 3b: both held valid through three grants
        drive(0, 1'b1, OP_OR, 4'h9, 4'h2);
        drive(1, 1'b1, OP_ADD, 4'h9, 4'h9);
        serve(0, 9'h00B, 1'b0, 1'b0, "tie1");
        tick();
`ifdef ARB_FIXED_PRIO_EN
        serve(0, 9'h00B, 1'b0, 1'b0, "tie2");
`else
        serve(1, 9'h102, 1'b0, 1'b0, "tie2");
`endif
        tick();
        serve(0, 9'h00B, 1'b0, 1'b1, "tie3");
        drive(1, 1'b0, OP_ADD, 4'h9, 4'h9);
        tick();

        // 4: illegal NOR never reaches the ALU
        drive(0, 1'b1, OP_NOR, 4'h3, 4'h3);
        serve(0, 9'h000, 1'b1, 1'b1, "t4");
        chk("t4_ctrl", alu_ctrl, 3'b000);
        chk("t4_ok", alu_ok, 1'b0);
        chk("t4_alu_idle", m_st, 2'd0);
        tick();

        // 5: stalled response, then the other requester is served
        u_req0.resp_ready = 1'b0;
        drive(0, 1'b1, OP_AND, 4'hF, 4'h5);
        serve(0, 9'h005, 1'b0, 1'b0, "t5");
        drive(1, 1'b1, OP_OR, 4'h1, 4'h2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_valid", u_req0.resp_valid, 1'b1);
            chk("t5_hold_data", u_req0.resp_data, 9'h005);
            chk("t5_no_ready0", u_req0.ready, 1'b0);
            chk("t5_no_ready1", u_req1.ready, 1'b0);
        end
        u_req0.resp_ready = 1'b1;
        u_req0.valid = 1'b0;
        tick();
        serve(1, 9'h003, 1'b0, 1'b1, "t5_req1");
        tick();

        // 6: reset during GO, then recovery
        drive(0, 1'b1, OP_MUL, 4'h2, 4'h3);
        #1;
        chk("t6_ready", u_req0.ready, 1'b1);
        tick();
        drive(0, 1'b0, OP_MUL, 4'h2, 4'h3);
        tick();
        chk("t6_go_ok", alu_ok, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6_rst_ok", alu_ok, 1'b0);
        chk("t6_rst_ack", alu_ack, 1'b0);
        chk("t6_rst_ctrl", alu_ctrl, 3'b000);
        chk("t6_rst_resp0", u_req0.resp_valid, 1'b0);
        chk("t6_rst_resp1", u_req1.resp_valid, 1'b0);
        chk("t6_alu_waitack", m_st, 2'd2);
        rst = 1'b0;
        tick();
        chk("t6_init_ack", alu_ack, 1'b1);
        tick();
        chk("t6_idle_ack", alu_ack, 1'b0);
        drive(0, 1'b1, OP_ADD, 4'h3, 4'h4);
        serve(0, 9'h007, 1'b0, 1'b1, "t6_after");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
